// File: rtl/mac_tx_fcs_append.sv
// Appends the 4-byte FCS from the mac_hard_crc stage to a 64-bit TX frame stream.
// Non-last words pass through a one-word holding register; the last word is merged with the FCS.
module mac_tx_fcs_append (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_data,
  input  logic [7:0]  s_be,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [63:0] m_data,
  output logic [7:0]  m_be,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [63:0] crc_din,
  output logic [7:0]  crc_din_valid,
  output logic        crc_rst,
  input  logic [31:0] crc_in
);

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StCrc,
    StTail1,
    StTail2
  } state_e;

  state_e      state_q, state_d;
  logic        hold_valid_q, hold_valid_d;
  logic [63:0] hold_data_q, hold_data_d;
  logic [63:0] last_data_q, last_data_d;
  logic [7:0]  last_be_q, last_be_d;
  logic [31:0] fcs_q, fcs_d;
  logic        crc_rst_q, crc_rst_d;
  logic        init_q;

  logic        accept;
  logic        drain;
  logic [3:0]  last_n;
  logic [63:0] last_mask;
  logic [63:0] tail1_data, tail2_data;
  logic [7:0]  tail1_be, tail2_be;

  function automatic logic [7:0] therm(input logic [3:0] k);
    logic [8:0] t;
    t = (9'd1 << k) - 9'd1;
    return t[7:0];
  endfunction

  // Byte count of the last word; s_be is a thermometer so a popcount suffices.
  always_comb begin
    last_n = '0;
    for (int i = 0; i < 8; i++) begin
      last_n = last_n + {3'b000, last_be_q[i]};
    end
  end

  always_comb begin
    last_mask = '0;
    for (int i = 0; i < 8; i++) begin
      last_mask[8*i +: 8] = {8{last_be_q[i]}};
    end
  end

  // FCS bytes start right after the last data byte; anything shifted past lane 7 goes to TAIL2.
  assign tail1_data = (last_data_q & last_mask) | ({32'h0, fcs_q} << {last_n, 3'b000});
  assign tail2_data = {32'h0, fcs_q >> {(4'd8 - last_n), 3'b000}};
  assign tail1_be   = (last_n <= 4'd4) ? therm(last_n + 4'd4) : 8'hFF;
  assign tail2_be   = therm(last_n - 4'd4);

  assign accept  = s_valid & s_ready;
  assign drain   = hold_valid_q & m_ready;
  assign crc_rst = crc_rst_q;

  assign crc_din       = accept ? s_data : '0;
  assign crc_din_valid = accept ? s_be : '0;

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_data  = hold_data_q;
    m_be    = hold_valid_q ? 8'hFF : 8'h00;
    m_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        s_ready = ~crc_rst_q;
        m_valid = hold_valid_q;
      end
      StData: begin
        s_ready = ~hold_valid_q | m_ready;
        m_valid = hold_valid_q;
      end
      StCrc: begin
        m_be = 8'h00;
      end
      StTail1: begin
        m_valid = 1'b1;
        m_data  = tail1_data;
        m_be    = tail1_be;
        m_last  = (last_n <= 4'd4);
      end
      StTail2: begin
        m_valid = 1'b1;
        m_data  = tail2_data;
        m_be    = tail2_be;
        m_last  = 1'b1;
      end
      default: begin
        s_ready = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    last_data_d  = last_data_q;
    last_be_d    = last_be_q;
    fcs_d        = fcs_q;
    crc_rst_d    = init_q | (m_valid & m_ready & m_last);
    unique case (state_q)
      StIdle, StData: begin
        if (drain) begin
          hold_valid_d = 1'b0;
        end
        if (accept) begin
          if (s_last) begin
            last_data_d = s_data;
            last_be_d   = s_be;
            state_d     = StCrc;
          end else begin
            hold_data_d  = s_data;
            hold_valid_d = 1'b1;
            state_d      = StData;
          end
        end
      end
      StCrc: begin
        fcs_d   = crc_in;
        state_d = StTail1;
      end
      StTail1: begin
        if (m_ready) begin
          state_d = (last_n <= 4'd4) ? StIdle : StTail2;
        end
      end
      StTail2: begin
        if (m_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      last_data_q  <= '0;
      last_be_q    <= '0;
      fcs_q        <= '0;
      crc_rst_q    <= 1'b1;
      init_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      last_data_q  <= last_data_d;
      last_be_q    <= last_be_d;
      fcs_q        <= fcs_d;
      crc_rst_q    <= crc_rst_d;
      init_q       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_tx_fcs_append.sv
// Scoreboard bench for mac_tx_fcs_append: expected output words are built from the frame bytes
// plus crc_in bytes and compared as the DUT emits them.
module tb_mac_tx_fcs_append;

  logic        clk;
  logic        rst;
  logic [63:0] s_data;
  logic [7:0]  s_be;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [63:0] m_data;
  logic [7:0]  m_be;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [63:0] crc_din;
  logic [7:0]  crc_din_valid;
  logic        crc_rst;
  logic [31:0] crc_val;

  mac_tx_fcs_append dut (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_data),
    .s_be          (s_be),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .m_data        (m_data),
    .m_be          (m_be),
    .m_valid       (m_valid),
    .m_last        (m_last),
    .m_ready       (m_ready),
    .crc_din       (crc_din),
    .crc_din_valid (crc_din_valid),
    .crc_rst       (crc_rst),
    .crc_in        (crc_val)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  be;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] fw[$];
  logic [7:0]  flast_be;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    int md;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      md = ready_mode;
      #1;
      case (md)
        1:       m_ready = 1'($urandom_range(0, 1));
        2:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: output scoreboard, crc feed, crc_rst pulse and inter-frame gap.
  initial begin
    bit pend = 0;
    bit in_frame = 0;
    bit have_prev = 0;
    int init_left = 2;
    int last_hs_edge = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend = 0;
        in_frame = 0;
        have_prev = 0;
        init_left = 2;
      end else begin
        check("crc_rst", crc_rst, (pend || init_left > 0));
        if (init_left > 0) init_left--;
        pend = 0;
        if (m_valid) begin
          if (sb.size() == 0) begin
            check("out_unexpected", m_valid, 0);
          end else begin
            e = sb[0];
            check("m_data", m_data, e.data);
            check("m_be", m_be, e.be);
            check("m_last", m_last, e.last);
            if (m_ready) begin
              void'(sb.pop_front());
              if (m_last) begin
                pend = 1;
                have_prev = 1;
                last_hs_edge = cyc + 1;
              end
            end
          end
        end
        if (s_valid && s_ready) begin
          check("crc_din_valid", crc_din_valid, s_be);
          check("crc_din", crc_din, s_data);
          if (!in_frame && have_prev) check("frame_gap_ok", ((cyc + 1 - last_hs_edge) >= 2), 1);
          in_frame = !s_last;
        end else begin
          check("crc_din_valid_idle", crc_din_valid, 8'h00);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic load_frame(input int nw, input logic [7:0] lbe);
    fw.delete();
    for (int w = 0; w < nw; w++) fw.push_back({$urandom, $urandom});
    flast_be = lbe;
  endtask

  task automatic push_expected();
    logic [7:0]  bytes[$];
    logic [63:0] word;
    int          n;
    exp_t        e;
    for (int w = 0; w < fw.size(); w++) begin
      word = fw[w];
      n = 8;
      if (w == fw.size() - 1) begin
        n = 0;
        for (int j = 0; j < 8; j++) if (flast_be[j]) n++;
      end
      for (int j = 0; j < n; j++) bytes.push_back(word[8*j +: 8]);
    end
    for (int k = 0; k < 4; k++) bytes.push_back(crc_val[8*k +: 8]);
    for (int i = 0; i < bytes.size(); i += 8) begin
      e.data = '0;
      e.be = '0;
      for (int j = 0; j < 8; j++) begin
        if (i + j < bytes.size()) begin
          e.data[8*j +: 8] = bytes[i+j];
          e.be[j] = 1'b1;
        end
      end
      e.last = (i + 8 >= bytes.size());
      sb.push_back(e);
    end
  endtask

  // Drives the loaded frame; stops after abort_after accepted words when nonzero.
  task automatic drive_frame(input int abort_after);
    bit acc;
    int t;
    push_expected();
    for (int w = 0; w < fw.size(); w++) begin
      s_data  = fw[w];
      s_last  = (w == fw.size() - 1);
      s_be    = s_last ? flast_be : 8'hFF;
      s_valid = 1'b1;
      acc = 0;
      t = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
        t++;
        if (!acc && t >= 300) begin
          check("s_ready_timeout", s_ready, 1);
          s_valid = 1'b0;
          return;
        end
      end
      if (abort_after != 0 && w + 1 == abort_after) begin
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() > 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("drain_left", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reset_release_checks();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rel0_crc_rst", crc_rst, 1);
    check("rel0_s_ready", s_ready, 0);
    @(negedge clk);
    check("rel1_crc_rst", crc_rst, 1);
    check("rel1_s_ready", s_ready, 0);
    @(negedge clk);
    check("rel2_crc_rst", crc_rst, 0);
    check("rel2_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] tmp;
    rst = 1'b0;
    s_data = '0;
    s_be = '0;
    s_valid = 1'b0;
    s_last = 1'b0;
    crc_val = 32'hA1B2C3D4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_be", m_be, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_crc_din_valid", crc_din_valid, 0);
    check("rst_crc_rst", crc_rst, 1);
    reset_release_checks();

    // 64-byte frame: FCS lands in a ninth word.
    load_frame(8, 8'hFF);
    drive_frame(0);
    wait_drain();

    // n=3: single tail word.
    load_frame(1, 8'h07);
    tmp = fw[0];
    tmp[23:0] = 24'hCCBBAA;
    fw[0] = tmp;
    drive_frame(0);
    wait_drain();

    // n=6: FCS spans TAIL1 and TAIL2.
    load_frame(1, 8'h3F);
    drive_frame(0);
    wait_drain();

    // Backpressure in TAIL1 with another word pending on the input.
    ready_mode = 2;
    load_frame(1, 8'h07);
    drive_frame(0);
    s_data  = 64'h0123456789ABCDEF;
    s_be    = 8'hFF;
    s_last  = 1'b0;
    s_valid = 1'b1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      check("stall_m_valid", m_valid, 1);
      if (sb.size() > 0) begin
        check("stall_m_data", m_data, sb[0].data);
        check("stall_m_be", m_be, sb[0].be);
      end
      check("stall_s_ready", s_ready, 0);
      check("stall_crc_din_valid", crc_din_valid, 0);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    ready_mode = 0;
    wait_drain();

    // Back-to-back frames, first with full readiness, then with random backpressure.
    crc_val = 32'h5E6F7A8B;
    load_frame(2, 8'hFF);
    drive_frame(0);
    load_frame(3, 8'h0F);
    drive_frame(0);
    ready_mode = 1;
    load_frame(2, 8'h1F);
    drive_frame(0);
    load_frame(1, 8'h01);
    drive_frame(0);
    load_frame(1, 8'hFF);
    drive_frame(0);
    load_frame(4, 8'h7F);
    drive_frame(0);
    load_frame(3, 8'h03);
    drive_frame(0);
    wait_drain();
    ready_mode = 0;
    wait_drain();

    // Reset mid-frame: the partial frame must vanish; the next frame is unaffected.
    crc_val = 32'hA1B2C3D4;
    load_frame(8, 8'hFF);
    drive_frame(3);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_m_last", m_last, 0);
    check("midrst_m_valid", m_valid, 0);
    @(negedge clk);
    check("midrst_crc_rst", crc_rst, 1);
    reset_release_checks();
    load_frame(8, 8'hFF);
    drive_frame(0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
